// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer core.
// One instruction is fetched, executed and retired per clock. Instruction
// and data reads are combinational and stores are captured by the memory on
// the clock edge. Sub-word stores are merged with drdata so that the memory
// always receives a full word.
module rv32i_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        ivalid,
    output logic [31:0] daddr,
    input  logic [31:0] drdata,
    input  logic        drvalid,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] rd_d;
    logic        rd_we;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_v, rs2_v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic        is_ls, is_store, stall;
    logic [3:0]  st_lanes;
    logic [31:0] st_rep, st_mask;

    assign opcode = idata[6:0];
    assign rd     = idata[11:7];
    assign f3     = idata[14:12];
    assign rs1    = idata[19:15];
    assign rs2    = idata[24:20];
    assign f7     = idata[31:25];

    assign imm_i = {{20{idata[31]}}, idata[31:20]};
    assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
    assign imm_b = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
    assign imm_u = {idata[31:12], 12'd0};
    assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};

    // x0 is reset to zero and never written, so it reads as zero directly
    assign rs1_v = regs_q[rs1];
    assign rs2_v = regs_q[rs2];
    assign iaddr = pc_q;

    function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, sa < sb};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    // Lane selection: bytes by addr[1:0], halfwords by addr[1], words unshifted
    function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Decode and execute; unrecognised encodings fall through as PC+4 with no writes
    always_comb begin
        pc_d     = pc_q + 32'd4;
        rd_we    = 1'b0;
        rd_d     = 32'd0;
        is_ls    = 1'b0;
        is_store = 1'b0;
        st_lanes = 4'b0000;
        st_rep   = rs2_v;
        daddr    = rs1_v + imm_i;
        case (opcode)
            OP_LUI: begin
                rd_we = 1'b1;
                rd_d  = imm_u;
            end
            OP_AUIPC: begin
                rd_we = 1'b1;
                rd_d  = pc_q + imm_u;
            end
            OP_JAL: begin
                rd_we = 1'b1;
                rd_d  = pc_q + 32'd4;
                pc_d  = pc_q + imm_j;
            end
            OP_JALR: begin
                if (f3 == 3'd0) begin
                    rd_we = 1'b1;
                    rd_d  = pc_q + 32'd4;
                    pc_d  = (rs1_v + imm_i) & 32'hFFFF_FFFE;
                end
            end
            OP_BRANCH: begin
                if (f3 != 3'd2 && f3 != 3'd3 && br_taken(f3, rs1_v, rs2_v))
                    pc_d = pc_q + imm_b;
            end
            OP_LOAD: begin
                if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) begin
                    is_ls = 1'b1;
                    rd_we = 1'b1;
                    rd_d  = load_ext(f3, daddr[1:0], drdata);
                end
            end
            OP_STORE: begin
                daddr = rs1_v + imm_s;
                if (f3 <= 3'd2) begin
                    is_ls    = 1'b1;
                    is_store = 1'b1;
                    case (f3)
                        3'd0: begin
                            st_lanes = 4'b0001 << daddr[1:0];
                            st_rep   = {4{rs2_v[7:0]}};
                        end
                        3'd1: begin
                            st_lanes = daddr[1] ? 4'b1100 : 4'b0011;
                            st_rep   = {2{rs2_v[15:0]}};
                        end
                        default: st_lanes = 4'b1111;
                    endcase
                end
            end
            OP_IMM: begin
                if ((f3 != 3'd1 || f7 == 7'd0) &&
                    (f3 != 3'd5 || (f7[6] == 1'b0 && f7[4:0] == 5'd0))) begin
                    rd_we = 1'b1;
                    rd_d  = alu(f3, f3 == 3'd5 && f7[5], rs1_v, imm_i);
                end
            end
            OP_REG: begin
                if (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    rd_we = 1'b1;
                    rd_d  = alu(f3, f7[5], rs1_v, rs2_v);
                end
            end
            default: ;
        endcase
        stall = !ivalid || (is_ls && !drvalid);
        if (stall) begin
            pc_d  = pc_q;
            rd_we = 1'b0;
        end
    end

    // Store merge: enabled lanes carry the new data, the rest are read back
    assign st_mask = {{8{st_lanes[3]}}, {8{st_lanes[2]}}, {8{st_lanes[1]}}, {8{st_lanes[0]}}};
    assign dwdata  = (drdata & ~st_mask) | (st_rep & st_mask);
    // Gated by rstn so a store in flight is dropped the moment reset asserts
    assign dwe     = (rstn && is_store && !stall) ? st_lanes : 4'b0000;

    // Program counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (rd_we && rd != 5'd0) begin
            regs_q[rd] <= rd_d;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: instruction-level reference model of RV32I compared against
// the core every cycle, directed programs with hand-computed results, then a
// randomized program with random fetch/data stalls.
module tb_rv32i_core;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] iaddr, idata, daddr, drdata, dwdata;
    logic        ivalid, drvalid;
    logic [3:0]  dwe;

    // Memory seen by the core (shared word-addressed TCM, 4 KB, decodes [11:2])
    logic [31:0] dmem [1024];
    // Memory and architectural state of the reference model
    logic [31:0] mmem [1024];
    logic [31:0] m_x  [32];
    logic [31:0] m_pc;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0]  p_we;
    logic [31:0] p_a, p_d;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, OPI = 7'b0010011, OPR = 7'b0110011;

    always #5 clk = ~clk;

    assign idata  = dmem[iaddr[11:2]];
    assign drdata = dmem[daddr[11:2]];

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstn(rstn), .iaddr(iaddr), .idata(idata), .ivalid(ivalid),
        .daddr(daddr), .drdata(drdata), .drvalid(drvalid), .dwdata(dwdata), .dwe(dwe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd, input logic [6:0] op);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm;
        return {t[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] t;
        t = imm;
        return {t[11:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:0], ST};
    endfunction
    function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] t;
        t = imm;
        return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:1], t[11], BR};
    endfunction
    function automatic logic [31:0] e_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm20;
        return {t[19:0], 5'(rd), op};
    endfunction
    function automatic logic [31:0] e_j(input int imm, input int rd);
        logic [31:0] t;
        t = imm;
        return {t[20], t[10:1], t[11], t[19:12], 5'(rd), JAL};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_alu(input logic [2:0] f, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = b[4:0];
        case (f)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << s;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> s) : a >> s;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic m_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    endtask

    // Compare this cycle's outputs with the model, then retire in the model
    task automatic model_cycle(input logic iv, input logic dv);
        logic [31:0] ins, a, b, ea, nxt, wb, word, merged, sh, im_i, im_b, im_j;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        we, mem_op, is_st, stall;
        logic [3:0]  lanes, exp_we;
        int          first, nbytes;
        ins  = mmem[m_pc[11:2]];
        check("iaddr", iaddr, m_pc);
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        a  = m_x[ins[19:15]];
        b  = m_x[ins[24:20]];
        im_i = {{20{ins[31]}}, ins[31:20]};
        im_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        im_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt = m_pc + 32'd4; we = 1'b0; wb = 32'd0; mem_op = 1'b0; is_st = 1'b0;
        lanes = 4'd0; merged = 32'd0; ea = 32'd0;
        case (op)
            LUI:   begin we = 1'b1; wb = {ins[31:12], 12'd0}; end
            AUIPC: begin we = 1'b1; wb = m_pc + {ins[31:12], 12'd0}; end
            JAL:   begin we = 1'b1; wb = m_pc + 32'd4; nxt = m_pc + im_j; end
            JALR:  if (f3 == 3'd0) begin
                       we = 1'b1; wb = m_pc + 32'd4; nxt = (a + im_i) & 32'hFFFF_FFFE;
                   end
            BR: begin
                case (f3)
                    3'd0: if (a == b) nxt = m_pc + im_b;
                    3'd1: if (a != b) nxt = m_pc + im_b;
                    3'd4: if ($signed(a) <  $signed(b)) nxt = m_pc + im_b;
                    3'd5: if ($signed(a) >= $signed(b)) nxt = m_pc + im_b;
                    3'd6: if (a <  b) nxt = m_pc + im_b;
                    3'd7: if (a >= b) nxt = m_pc + im_b;
                    default: ;
                endcase
            end
            LD: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                mem_op = 1'b1; we = 1'b1; ea = a + im_i;
                word = mmem[ea[11:2]];
                case (f3)
                    3'd0: begin sh = word >> (8 * ea[1:0]); wb = {{24{sh[7]}}, sh[7:0]}; end
                    3'd4: begin sh = word >> (8 * ea[1:0]); wb = {24'd0, sh[7:0]}; end
                    3'd1: begin sh = word >> (16 * ea[1]);  wb = {{16{sh[15]}}, sh[15:0]}; end
                    3'd5: begin sh = word >> (16 * ea[1]);  wb = {16'd0, sh[15:0]}; end
                    default: wb = word;
                endcase
            end
            ST: if (f3 <= 3'd2) begin
                mem_op = 1'b1; is_st = 1'b1;
                ea = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
                word   = mmem[ea[11:2]];
                first  = (f3 == 3'd0) ? int'(ea[1:0]) : (f3 == 3'd1) ? 2 * int'(ea[1]) : 0;
                nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
                for (int k = 0; k < 4; k++) begin
                    if (k >= first && k < first + nbytes) begin
                        lanes[k] = 1'b1;
                        merged[8*k +: 8] = b[8*(k-first) +: 8];
                    end else begin
                        merged[8*k +: 8] = word[8*k +: 8];
                    end
                end
            end
            OPI: if ((f3 != 3'd1 || f7 == 7'd0) && (f3 != 3'd5 || f7 == 7'd0 || f7 == 7'h20)) begin
                we = 1'b1; wb = m_alu(f3, f3 == 3'd5 && f7 == 7'h20, a, im_i);
            end
            OPR: if (f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                we = 1'b1; wb = m_alu(f3, f7 == 7'h20, a, b);
            end
            default: ;
        endcase
        stall  = !iv || (mem_op && !dv);
        exp_we = (is_st && !stall) ? lanes : 4'd0;
        check("dwe", {28'd0, dwe}, {28'd0, exp_we});
        if (exp_we != 4'd0) check("dwdata", dwdata, merged);
        if (mem_op && iv) check("daddr", daddr, ea);
        if (!stall) begin
            if (we && rd != 5'd0) m_x[rd] = wb;
            if (is_st) mmem[ea[11:2]] = merged;
            m_pc = nxt;
        end
    endtask

    // One clock: drive inputs after the edge, compare at negedge, sample the
    // store just before the next edge and apply it to memory after that edge.
    task automatic cycle(input logic iv, input logic dv);
        ivalid  = iv;
        drvalid = dv;
        @(negedge clk);
        if (rstn) model_cycle(iv, dv);
        else begin
            check("iaddr_in_reset", iaddr, 32'd0);
            check("dwe_in_reset", {28'd0, dwe}, 32'd0);
        end
        #4;
        p_we = dwe; p_a = daddr; p_d = dwdata;
        @(posedge clk);
        #1;
        if (p_we != 4'd0) dmem[p_a[11:2]] = p_d;
    endtask

    task automatic run_until(input logic [31:0] target, input int bound, input string name);
        int n;
        n = 0;
        while (iaddr !== target && n < bound) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        check(name, iaddr, target);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin dmem[i] = 32'd0; mmem[i] = 32'd0; end
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dmem[idx] = w;
        mmem[idx] = w;
    endtask

    function automatic logic [31:0] rand_instr(input logic [31:0] pc);
        int k, rd, r1, r2, f3, imm;
        k  = $urandom_range(0, 99);
        rd = $urandom_range(0, 31); r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31);
        f3 = $urandom_range(0, 7);
        if (k < 25)
            return e_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, r2, r1, f3, rd, OPR);
        if (k < 50) begin
            imm = $urandom_range(0, 4095);
            if (f3 == 1) imm = imm & 31;
            if (f3 == 5) imm = (imm & 31) | ($urandom_range(0, 1) == 1 ? 32'h400 : 0);
            return e_i(imm, r1, f3, rd, OPI);
        end
        if (k < 58) return e_u($urandom, rd, ($urandom_range(0, 1) == 1) ? LUI : AUIPC);
        if (k < 70) begin
            case ($urandom_range(0, 4))
                0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
            endcase
            return e_i(-$urandom_range(1, 2048), 0, f3, rd, LD);
        end
        if (k < 82) return e_s(-$urandom_range(1, 2048), r2, 0, $urandom_range(0, 2));
        if (k < 92) begin
            case ($urandom_range(0, 5))
                0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
            endcase
            return e_b(($urandom_range(0, 1) == 1) ? 12 : 8, r2, r1, f3);
        end
        if (k < 95) return e_j(8, rd);
        if (k < 97) return e_i(int'(pc) + 8 + $urandom_range(0, 1), 0, 0, rd, JALR);
        case ($urandom_range(0, 3))
            0:       return {$urandom_range(0, 32'h1FF_FFFF), 7'b0001111};
            1:       return 32'h0000_0073;
            2:       return {$urandom_range(0, 32'h1FF_FFFF), 7'b1110011};
            default: return {$urandom_range(0, 32'h1FF_FFFF), 7'b1111111};
        endcase
    endfunction

    initial begin
        logic [31:0] prog [$];
        int          nmis, pcw, halt_w;
        rstn = 1'b0; ivalid = 1'b1; drvalid = 1'b1;
        p_we = 4'd0; p_a = 32'd0; p_d = 32'd0;
        clear_mem();
        m_reset();
        @(posedge clk);
        #1;

        // Reset then a zeroed memory: all-zero words execute as NOP
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1);
            check("nop_advance", iaddr, 32'(4 * (k + 1)));
        end

        // Directed program
        rstn = 1'b0;
        m_reset();
        prog = {};
        prog.push_back(e_s(32'h300, 5, 0, 2));          // 00 SW x5,0x300(x0)
        prog.push_back(e_i(-5, 0, 0, 1, OPI));          // 04 ADDI x1,x0,-5
        prog.push_back(e_i(3, 0, 0, 2, OPI));           // 08 ADDI x2,x0,3
        prog.push_back(e_r(0, 2, 1, 2, 3, OPR));        // 0C SLT x3,x1,x2
        prog.push_back(e_r(0, 2, 1, 3, 4, OPR));        // 10 SLTU x4,x1,x2
        prog.push_back(e_i(32'h401, 1, 5, 5, OPI));     // 14 SRAI x5,x1,1
        prog.push_back(e_i(7, 0, 0, 0, OPI));           // 18 ADDI x0,x0,7
        prog.push_back(32'h0000_0000);                  // 1C NOP
        prog.push_back(e_j(8, 1));                      // 20 JAL x1,+8
        prog.push_back(e_j(28, 0));                     // 24 JAL x0,+0x1C -> 0x40
        prog.push_back(e_i(1, 1, 0, 0, JALR));          // 28 JALR x0,x1,1 -> 0x24
        for (int k = 0; k < 5; k++) prog.push_back(32'h0000_0000);
        prog.push_back(e_s(32'h304, 3, 0, 2));          // 40
        prog.push_back(e_s(32'h308, 4, 0, 2));          // 44
        prog.push_back(e_s(32'h30C, 5, 0, 2));          // 48
        prog.push_back(e_s(32'h310, 0, 0, 2));          // 4C
        prog.push_back(e_s(32'h314, 1, 0, 2));          // 50
        prog.push_back(e_u(32'h12345, 7, LUI));         // 54
        prog.push_back(e_i(32'h678, 7, 0, 7, OPI));     // 58
        prog.push_back(e_s(32'h100, 7, 0, 2));          // 5C SW
        prog.push_back(e_i(32'hAB, 0, 0, 8, OPI));      // 60
        prog.push_back(e_s(32'h101, 8, 0, 0));          // 64 SB x8,0x101
        prog.push_back(e_i(32'h100, 0, 2, 9, LD));      // 68 LW
        prog.push_back(e_i(32'h101, 0, 0, 10, LD));     // 6C LB
        prog.push_back(e_i(32'h101, 0, 4, 11, LD));     // 70 LBU
        prog.push_back(e_i(32'h100, 0, 1, 12, LD));     // 74 LH
        prog.push_back(e_s(32'h318, 9, 0, 2));          // 78
        prog.push_back(e_s(32'h31C, 10, 0, 2));         // 7C
        prog.push_back(e_s(32'h320, 11, 0, 2));         // 80
        prog.push_back(e_s(32'h324, 12, 0, 2));         // 84
        prog.push_back(e_b(8, 0, 0, 0));                // 88 BEQ taken
        prog.push_back(e_i(1, 0, 0, 13, OPI));          // 8C skipped
        prog.push_back(e_b(8, 0, 0, 1));                // 90 BNE not taken
        prog.push_back(e_i(2, 0, 0, 14, OPI));          // 94
        prog.push_back(e_s(32'h328, 13, 0, 2));         // 98
        prog.push_back(e_s(32'h32C, 14, 0, 2));         // 9C
        prog.push_back(32'h0000_0073);                  // A0 ECALL
        prog.push_back(e_j(0, 0));                      // A4 halt
        for (int k = 0; k < prog.size(); k++) put(k, prog[k]);
        cycle(1'b1, 1'b1);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
        check("pc_before_stall", iaddr, 32'h0C);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1);
            check("ivalid_stall_pc", iaddr, 32'h0C);
        end
        run_until(32'h64, 100, "reach_sb");
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0);
            check("sb_drvalid_stall_dwe", {28'd0, p_we}, 32'd0);
            check("sb_drvalid_stall_pc", iaddr, 32'h64);
        end
        cycle(1'b1, 1'b1);
        check("sb_dwe", {28'd0, p_we}, 32'h2);
        check("sb_commit_pc", iaddr, 32'h68);
        run_until(32'hA4, 200, "reach_halt");
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
        check("slt",       dmem[32'h304 >> 2], 32'h1);
        check("sltu",      dmem[32'h308 >> 2], 32'h0);
        check("srai",      dmem[32'h30C >> 2], 32'hFFFF_FFFD);
        check("x0_zero",   dmem[32'h310 >> 2], 32'h0);
        check("jal_link",  dmem[32'h314 >> 2], 32'h24);
        check("mem_word",  dmem[32'h100 >> 2], 32'h1234_AB78);
        check("lw",        dmem[32'h318 >> 2], 32'h1234_AB78);
        check("lb",        dmem[32'h31C >> 2], 32'hFFFF_FFAB);
        check("lbu",       dmem[32'h320 >> 2], 32'h0000_00AB);
        check("lh",        dmem[32'h324 >> 2], 32'hFFFF_AB78);
        check("beq_skip",  dmem[32'h328 >> 2], 32'h0);
        check("bne_fall",  dmem[32'h32C >> 2], 32'h2);

        // Reset clears registers; then an asynchronous reset during a store
        rstn = 1'b0;
        m_reset();
        put(32'h300 >> 2, 32'hDEAD_BEEF);
        put(32'h304 >> 2, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b1);
        rstn = 1'b1;
        run_until(32'h40, 100, "reach_sw_x3");
        check("regs_cleared", dmem[32'h300 >> 2], 32'h0);
        ivalid = 1'b1; drvalid = 1'b1;
        #2;
        check("sw_dwe_before_reset", {28'd0, dwe}, 32'hF);
        rstn = 1'b0;
        #1;
        check("async_reset_iaddr", iaddr, 32'h0);
        check("async_reset_dwe", {28'd0, dwe}, 32'h0);
        m_reset();
        cycle(1'b1, 1'b1);
        check("store_suppressed", dmem[32'h304 >> 2], 32'hDEAD_BEEF);
        rstn = 1'b1;
        run_until(32'hA4, 200, "reach_halt_2");
        check("slt_rerun", dmem[32'h304 >> 2], 32'h1);

        // Randomized program with random stalls
        rstn = 1'b0;
        m_reset();
        clear_mem();
        for (int i = 512; i < 1024; i++) put(i, $urandom);
        pcw = 0;
        for (int k = 0; k < 400; k++) begin put(pcw, rand_instr(32'(4 * pcw))); pcw++; end
        for (int r = 1; r < 32; r++) begin put(pcw, e_s(-2048 + 4 * r, r, 0, 2)); pcw++; end
        halt_w = pcw;
        for (int k = 0; k < 4; k++) begin put(pcw, e_j(0, 0)); pcw++; end
        cycle(1'b1, 1'b1);
        rstn = 1'b1;
        for (int k = 0; k < 2500; k++)
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
        check("rand_halted", {31'd0, (iaddr >= 32'(4 * halt_w)) && (iaddr < 32'(4 * pcw))}, 32'd1);
        nmis = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== mmem[i]) nmis++;
        check("rand_mem_image", 32'(nmis), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I integer core: one instruction fetched, executed and retired per clock when both memory ports are ready.
- Sits between a combinational-read instruction port and a combinational-read / synchronous-write data port, typically a shared word-addressed TCM.
- Memory decodes only address bits [31:2]; byte/halfword stores are merged by the core into a full word.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, asynchronous, active-low.
- iaddr  output  32  fetch address; equals PC.
- idata  input  32  instruction word at iaddr, valid combinationally in the same cycle.
- ivalid  input  1  idata valid; low stalls the core.
- daddr  output  32  data byte address; equals ALU result (rs1+imm for loads/stores).
- drdata  input  32  word at daddr[31:2], combinational.
- drvalid  input  1  drdata valid; low stalls loads and stores.
- dwdata  output  32  full merged store word.
- dwe  output  4  store byte enables; the memory writes the whole dwdata word when dwe != 0.

Behaviour:
- Reset (rstn low, asynchronous): PC=RESET_PC, x1..x31=0. While in reset: iaddr=RESET_PC, dwe=0.
- First instruction is fetched at RESET_PC in the first cycle after reset release.
- Each cycle: decode idata, read rs1/rs2, execute. At the clock edge commit the rd write and the PC update.
- Stall: if ivalid=0, or the instruction is a load/store and drvalid=0, then no register write, no PC change, and dwe=0.
- Register file: 32x32. x0 reads 0 and writes are discarded. Two combinational read ports, one write port.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- FENCE, ECALL, EBREAK, CSR and any unrecognised encoding execute as NOP: PC+4, no writes.
- Immediates: I/S/B/U/J formats, sign-extended to 32 bits.
- Shift amounts: rs2[4:0] or shamt.
- Arithmetic: 32-bit wrap-around, no overflow flags.
- PC next:
  - taken branch / JAL: PC+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - else: PC+4.
  - JAL/JALR write PC+4 to rd. If rd=rs1 for JALR, the target uses the old rs1.
- Misaligned targets and misaligned data accesses do not trap. PC bits [1:0] are ignored by memory.
- Loads: select from drdata by daddr[1:0].
  - Byte: lane daddr[1:0].
  - Halfword: lane daddr[1] (daddr[0] ignored).
  - Word: daddr[1:0] ignored.
  - Sign- or zero-extend per funct3.
- Stores: dwe asserted combinationally in the store cycle; the memory captures on that clock edge.
  - SW: dwe=4'b1111, dwdata=rs2.
  - SH: dwe=0011 or 1100 by daddr[1]; new halfword placed in that lane, other lane taken from drdata.
  - SB: dwe one-hot by daddr[1:0]; rs2[7:0] placed in that lane, other bytes from drdata.
- dwe=0 for all non-store instructions.
- daddr is driven for every instruction; its value only matters for loads and stores.
- Reset asserted mid-program: state is cleared immediately. Any store in flight is suppressed because dwe goes to 0 asynchronously.

Test Plan:
- Reset/fetch: hold rstn=0, release with memory zeroed → iaddr=0 first cycle. 0x00000000 decodes as NOP, so iaddr advances by 4 each cycle and dwe stays 0.
- ALU: ADDI x1,x0,-5; ADDI x2,x0,3; SLT x3,x1,x2; SLTU x4,x1,x2; SRA x5,x1,1 → x3=1, x4=0, x5=0xFFFFFFFD. Writes to x0 leave x0=0.
- Load/store: SW 0x12345678 to 0x100; SB 0xAB to 0x101; LW, LB, LBU, LH from 0x100/0x101:
  - word 0x1234AB78.
  - LB 0x101 = 0xFFFFFFAB, LBU = 0x000000AB.
  - LH 0x100 = 0xFFFFAB78.
  - SB cycle shows dwe=0010.
- Control flow:
  - BEQ taken skips the next instruction.
  - BNE not taken falls through.
  - JAL x1,+8 at 0x20 → PC=0x28, x1=0x24.
  - JALR x0,x1,1 → PC=0x24 (bit0 cleared).
- Stalls: drive ivalid=0 for 3 cycles → PC and registers frozen. A store with drvalid=0 keeps dwe=0 until drvalid=1, then commits once.
- Async reset mid-run: assert rstn=0 between clock edges → iaddr=0 and dwe=0 immediately, registers read 0 after release.
